coeff_token_enc48: RTL and testbench

COEFF_TOKEN_ENC48 -- requirements
Module: coeff_token_enc48

---
 rtl/coeff_token_enc48.sv | 161 ++++++++++++++++
 tb/tb_coeff_token_enc48.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_token_enc48.sv
// H.264 coeff_token encoder for the 4<=nC<8 table column, streamed out MSB first.
// Define COEFF_TOKEN_STATS_EN to add the BitCount output counting delivered bits.
module coeff_token_enc48 (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  TotalCoeff,
  input  logic [1:0]  TrailingOnes,
  output logic        BitValid,
  input  logic        BitReady,
  output logic        Bit,
  output logic        LastBit,
  output logic        Err
`ifdef COEFF_TOKEN_STATS_EN
  ,
  output logic [15:0] BitCount
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     r_state;
  logic [9:0] r_shift;
  logic [3:0] r_cnt;
  logic       r_alive;
  logic       r_err;

  logic [3:0] w_len;
  logic [9:0] w_code;
  logic [9:0] w_aligned;
  logic       w_illegal;
  logic       w_accept;
  logic       w_load;
  logic       w_lastBit;

  // Codeword lookup: w_code holds the codeword right-aligned, w_len its length.
  always_comb begin
    w_len  = 4'd0;
    w_code = 10'd0;
    case ({TotalCoeff, TrailingOnes})
      {5'd0,  2'd0}: begin w_len = 4'd4;  w_code = 10'b1111;       end
      {5'd1,  2'd0}: begin w_len = 4'd6;  w_code = 10'b001111;     end
      {5'd1,  2'd1}: begin w_len = 4'd4;  w_code = 10'b1110;       end
      {5'd2,  2'd0}: begin w_len = 4'd6;  w_code = 10'b001011;     end
      {5'd2,  2'd1}: begin w_len = 4'd5;  w_code = 10'b01111;      end
      {5'd2,  2'd2}: begin w_len = 4'd4;  w_code = 10'b1101;       end
      {5'd3,  2'd0}: begin w_len = 4'd6;  w_code = 10'b001000;     end
      {5'd3,  2'd1}: begin w_len = 4'd5;  w_code = 10'b01100;      end
      {5'd3,  2'd2}: begin w_len = 4'd5;  w_code = 10'b01110;      end
      {5'd3,  2'd3}: begin w_len = 4'd4;  w_code = 10'b1100;       end
      {5'd4,  2'd0}: begin w_len = 4'd7;  w_code = 10'b0001111;    end
      {5'd4,  2'd1}: begin w_len = 4'd5;  w_code = 10'b01010;      end
      {5'd4,  2'd2}: begin w_len = 4'd5;  w_code = 10'b01011;      end
      {5'd4,  2'd3}: begin w_len = 4'd4;  w_code = 10'b1011;       end
      {5'd5,  2'd0}: begin w_len = 4'd7;  w_code = 10'b0001011;    end
      {5'd5,  2'd1}: begin w_len = 4'd5;  w_code = 10'b01000;      end
      {5'd5,  2'd2}: begin w_len = 4'd5;  w_code = 10'b01001;      end
      {5'd5,  2'd3}: begin w_len = 4'd4;  w_code = 10'b1010;       end
      {5'd6,  2'd0}: begin w_len = 4'd7;  w_code = 10'b0001001;    end
      {5'd6,  2'd1}: begin w_len = 4'd6;  w_code = 10'b001110;     end
      {5'd6,  2'd2}: begin w_len = 4'd6;  w_code = 10'b001101;     end
      {5'd6,  2'd3}: begin w_len = 4'd4;  w_code = 10'b1001;       end
      {5'd7,  2'd0}: begin w_len = 4'd7;  w_code = 10'b0001000;    end
      {5'd7,  2'd1}: begin w_len = 4'd6;  w_code = 10'b001010;     end
      {5'd7,  2'd2}: begin w_len = 4'd6;  w_code = 10'b001001;     end
      {5'd7,  2'd3}: begin w_len = 4'd4;  w_code = 10'b1000;       end
      {5'd8,  2'd0}: begin w_len = 4'd8;  w_code = 10'b00001111;   end
      {5'd8,  2'd1}: begin w_len = 4'd7;  w_code = 10'b0001110;    end
      {5'd8,  2'd2}: begin w_len = 4'd7;  w_code = 10'b0001101;    end
      {5'd8,  2'd3}: begin w_len = 4'd5;  w_code = 10'b01101;      end
      {5'd9,  2'd0}: begin w_len = 4'd8;  w_code = 10'b00001011;   end
      {5'd9,  2'd1}: begin w_len = 4'd8;  w_code = 10'b00001110;   end
      {5'd9,  2'd2}: begin w_len = 4'd7;  w_code = 10'b0001010;    end
      {5'd9,  2'd3}: begin w_len = 4'd6;  w_code = 10'b001100;     end
      {5'd10, 2'd0}: begin w_len = 4'd9;  w_code = 10'b000001111;  end
      {5'd10, 2'd1}: begin w_len = 4'd8;  w_code = 10'b00001010;   end
      {5'd10, 2'd2}: begin w_len = 4'd8;  w_code = 10'b00001101;   end
      {5'd10, 2'd3}: begin w_len = 4'd7;  w_code = 10'b0001100;    end
      {5'd11, 2'd0}: begin w_len = 4'd9;  w_code = 10'b000001011;  end
      {5'd11, 2'd1}: begin w_len = 4'd9;  w_code = 10'b000001110;  end
      {5'd11, 2'd2}: begin w_len = 4'd8;  w_code = 10'b00001001;   end
      {5'd11, 2'd3}: begin w_len = 4'd8;  w_code = 10'b00001100;   end
      {5'd12, 2'd0}: begin w_len = 4'd9;  w_code = 10'b000001000;  end
      {5'd12, 2'd1}: begin w_len = 4'd9;  w_code = 10'b000001010;  end
      {5'd12, 2'd2}: begin w_len = 4'd9;  w_code = 10'b000001101;  end
      {5'd12, 2'd3}: begin w_len = 4'd8;  w_code = 10'b00001000;   end
      {5'd13, 2'd0}: begin w_len = 4'd10; w_code = 10'b0000001101; end
      {5'd13, 2'd1}: begin w_len = 4'd9;  w_code = 10'b000000111;  end
      {5'd13, 2'd2}: begin w_len = 4'd9;  w_code = 10'b000001001;  end
      {5'd13, 2'd3}: begin w_len = 4'd9;  w_code = 10'b000001100;  end
      {5'd14, 2'd0}: begin w_len = 4'd10; w_code = 10'b0000001001; end
      {5'd14, 2'd1}: begin w_len = 4'd10; w_code = 10'b0000001100; end
      {5'd14, 2'd2}: begin w_len = 4'd10; w_code = 10'b0000001011; end
      {5'd14, 2'd3}: begin w_len = 4'd10; w_code = 10'b0000001010; end
      {5'd15, 2'd0}: begin w_len = 4'd10; w_code = 10'b0000000101; end
      {5'd15, 2'd1}: begin w_len = 4'd10; w_code = 10'b0000001000; end
      {5'd15, 2'd2}: begin w_len = 4'd10; w_code = 10'b0000000111; end
      {5'd15, 2'd3}: begin w_len = 4'd10; w_code = 10'b0000000110; end
      {5'd16, 2'd0}: begin w_len = 4'd10; w_code = 10'b0000000001; end
      {5'd16, 2'd1}: begin w_len = 4'd10; w_code = 10'b0000000100; end
      {5'd16, 2'd2}: begin w_len = 4'd10; w_code = 10'b0000000011; end
      {5'd16, 2'd3}: begin w_len = 4'd10; w_code = 10'b0000000010; end
      default: ;
    endcase
  end

  // TrailingOnes is only 2 bits wide, so the T1>3 case cannot occur.
  assign w_illegal = (TotalCoeff > 5'd16) || ({3'b000, TrailingOnes} > TotalCoeff);
  assign w_aligned = w_code << (4'd10 - w_len);

  assign w_lastBit = (r_state == SHIFT) && (r_cnt == 4'd1);
  assign InReady   = r_alive && ((r_state == IDLE) || (w_lastBit && BitReady));
  assign w_accept  = InValid && InReady;
  assign w_load    = w_accept && !w_illegal;

  assign BitValid  = (r_state == SHIFT);
  assign Bit       = r_shift[9];
  assign LastBit   = w_lastBit;
  assign Err       = r_err;

  // A load on the final consumed bit takes priority so the stream stays gap-free.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_shift <= 10'd0;
      r_cnt   <= 4'd0;
      r_alive <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_err   <= w_accept && w_illegal;
      if (w_load) begin
        r_shift <= w_aligned;
        r_cnt   <= w_len;
        r_state <= SHIFT;
      end else if ((r_state == SHIFT) && BitReady) begin
        r_shift <= {r_shift[8:0], 1'b0};
        r_cnt   <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_state <= IDLE;
        end
      end
    end
  end

`ifdef COEFF_TOKEN_STATS_EN
  logic [15:0] r_bitCount;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_bitCount <= 16'd0;
    end else if (BitValid && BitReady) begin
      r_bitCount <= r_bitCount + 16'd1;
    end
  end

  assign BitCount = r_bitCount;
`endif

endmodule

// File: tb/tb_coeff_token_enc48.sv
// Self-checking bench for coeff_token_enc48: spec vectors, hand sequences and a
// randomized run checked against a bit-queue model of the serial stream.
module tb_coeff_token_enc48;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  TotalCoeff = 5'd0;
  logic [1:0]  TrailingOnes = 2'd0;
  logic        BitValid;
  logic        BitReady = 1'b0;
  logic        Bit;
  logic        LastBit;
  logic        Err;
`ifdef COEFF_TOKEN_STATS_EN
  logic [15:0] BitCount;
`endif

  int compared = 0;
  int mismatched = 0;

  string codeTab [68];
  bit    q [$];
  bit    errExp = 1'b0;
  bit    alive = 1'b0;
  int    statCnt = 0;

  logic obsIn, obsValid, obsBit, obsLast, obsErr;

  typedef struct {
    int    tc;
    int    t1;
    bit    toggle;
    string code;
    bit    err;
  } vec_t;

  vec_t vecs [$];

  coeff_token_enc48 dut (
    .Clk          (Clk),
    .nReset       (nReset),
    .InValid      (InValid),
    .InReady      (InReady),
    .TotalCoeff   (TotalCoeff),
    .TrailingOnes (TrailingOnes),
    .BitValid     (BitValid),
    .BitReady     (BitReady),
    .Bit          (Bit),
    .LastBit      (LastBit),
    .Err          (Err)
`ifdef COEFF_TOKEN_STATS_EN
    ,
    .BitCount     (BitCount)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic bit legal(int tc, int t1);
    return (tc <= 16) && (t1 <= tc);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkString(string name, string act, string exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic applyStimulus(string tag);
    logic expIn, expValid, expBit, expLast;
    string s;
    int tc, t1;
    @(negedge Clk);
    expValid = (q.size() != 0);
    expIn    = alive && ((q.size() == 0) || ((q.size() == 1) && BitReady));
    expBit   = expValid ? q[0] : 1'b0;
    expLast  = (q.size() == 1);
    obsIn    = InReady;
    obsValid = BitValid;
    obsBit   = Bit;
    obsLast  = LastBit;
    obsErr   = Err;
    checkOutput({tag, " outputs"},
                {27'd0, InReady, BitValid, (BitValid ? Bit : 1'b0), LastBit, Err},
                {27'd0, expIn, expValid, expBit, expLast, errExp});
`ifdef COEFF_TOKEN_STATS_EN
    checkOutput({tag, " BitCount"}, {16'd0, BitCount}, {16'd0, statCnt[15:0]});
`endif
    if (expValid && BitReady) begin
      void'(q.pop_front());
      statCnt++;
    end
    tc = int'(TotalCoeff);
    t1 = int'(TrailingOnes);
    errExp = InValid && expIn && !legal(tc, t1);
    if (InValid && expIn && legal(tc, t1)) begin
      s = codeTab[tc * 4 + t1];
      for (int i = 0; i < s.len(); i++) q.push_back(s.getc(i) == 8'h31);
    end
    alive = nReset;
    @(posedge Clk);
    #1;
  endtask

  task automatic assertReset();
    nReset = 1'b0;
    #1;
    checkOutput("async reset outputs", {27'd0, InReady, BitValid, Bit, LastBit, Err}, 32'd0);
    q.delete();
    errExp  = 1'b0;
    alive   = 1'b0;
    statCnt = 0;
  endtask

  task automatic runVector(vec_t v, int idx);
    string got = "";
    int errs = 0;
    bit done = 1'b0;
    InValid      = 1'b1;
    TotalCoeff   = v.tc[4:0];
    TrailingOnes = v.t1[1:0];
    BitReady     = 1'b1;
    applyStimulus($sformatf("vec%0d offer", idx));
    InValid = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      BitReady = v.toggle ? (k % 2 == 0) : 1'b1;
      applyStimulus($sformatf("vec%0d c%0d", idx, k));
      if (obsErr) errs++;
      if (obsValid && BitReady) got = {got, (obsBit ? "1" : "0")};
      if (obsValid && obsLast && BitReady) done = 1'b1;
      if (v.err && k == 3) done = 1'b1;
    end
    checkString($sformatf("vec%0d codeword", idx), got, v.code);
    checkOutput($sformatf("vec%0d err pulses", idx), errs, {31'd0, v.err});
  endtask

  initial begin
    string got;
    int valids;

    codeTab = '{
      "1111", "", "", "",
      "001111", "1110", "", "",
      "001011", "01111", "1101", "",
      "001000", "01100", "01110", "1100",
      "0001111", "01010", "01011", "1011",
      "0001011", "01000", "01001", "1010",
      "0001001", "001110", "001101", "1001",
      "0001000", "001010", "001001", "1000",
      "00001111", "0001110", "0001101", "01101",
      "00001011", "00001110", "0001010", "001100",
      "000001111", "00001010", "00001101", "0001100",
      "000001011", "000001110", "00001001", "00001100",
      "000001000", "000001010", "000001101", "00001000",
      "0000001101", "000000111", "000001001", "000001100",
      "0000001001", "0000001100", "0000001011", "0000001010",
      "0000000101", "0000001000", "0000000111", "0000000110",
      "0000000001", "0000000100", "0000000011", "0000000010"};

    vecs.push_back('{0,  0, 1'b0, "1111",       1'b0});
    vecs.push_back('{2,  1, 1'b1, "01111",      1'b0});
    vecs.push_back('{2,  3, 1'b0, "",           1'b1});
    vecs.push_back('{3,  3, 1'b0, "1100",       1'b0});
    vecs.push_back('{16, 3, 1'b0, "0000000010", 1'b0});
    vecs.push_back('{8,  0, 1'b1, "00001111",   1'b0});
    vecs.push_back('{13, 1, 1'b0, "000000111",  1'b0});
    vecs.push_back('{17, 0, 1'b0, "",           1'b1});
    vecs.push_back('{4,  3, 1'b1, "1011",       1'b0});
    vecs.push_back('{1,  1, 1'b0, "1110",       1'b0});
    vecs.push_back('{0,  1, 1'b0, "",           1'b1});

    #2;
    checkOutput("reset state outputs", {27'd0, InReady, BitValid, Bit, LastBit, Err}, 32'd0);
    applyStimulus("in reset");
    applyStimulus("in reset");
    nReset = 1'b1;
    applyStimulus("first edge after release");
    applyStimulus("idle");

`ifdef COEFF_TOKEN_STATS_EN
    runVector('{0, 0, 1'b0, "1111",   1'b0}, 100);
    runVector('{1, 1, 1'b0, "1110",   1'b0}, 101);
    runVector('{3, 0, 1'b0, "001000", 1'b0}, 102);
    checkOutput("stats BitCount after three tokens", {16'd0, BitCount}, 32'd14);
`endif

    foreach (vecs[i]) runVector(vecs[i], i);

    // Back-to-back tokens: second offered on the last bit of the first.
    InValid = 1'b1; TotalCoeff = 5'd1; TrailingOnes = 2'd0; BitReady = 1'b1;
    applyStimulus("b2b offer1");
    got = "";
    valids = 0;
    for (int k = 0; k < 16; k++) begin
      InValid = (k == 5);
      TotalCoeff = 5'd16;
      applyStimulus($sformatf("b2b c%0d", k));
      if (obsValid) valids++;
      if (obsValid && BitReady) got = {got, (obsBit ? "1" : "0")};
      if (k == 5) checkOutput("b2b ready+last on sixth bit", {30'd0, obsIn, obsLast}, 32'd3);
    end
    checkString("b2b stream", got, "0011110000000001");
    checkOutput("b2b valid cycles", valids, 32'd16);
    InValid = 1'b0;
    applyStimulus("b2b drain");

    // Reset during the fifth bit of TC=16,T1=3.
    InValid = 1'b1; TotalCoeff = 5'd16; TrailingOnes = 2'd3; BitReady = 1'b1;
    applyStimulus("rst offer");
    InValid = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus($sformatf("rst bit%0d", k + 1));
    assertReset();
    applyStimulus("rst held");
    applyStimulus("rst held");
    nReset = 1'b1;
    valids = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus($sformatf("rst after c%0d", k));
      if (obsValid) valids++;
    end
    checkOutput("no bits after reset release", valids, 32'd0);

    // Randomized traffic against the model, including occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        assertReset();
        applyStimulus("rand reset");
        nReset = 1'b1;
      end
      InValid      = ($urandom_range(0, 9) < 4);
      TotalCoeff   = 5'($urandom_range(0, 18));
      TrailingOnes = 2'($urandom_range(0, 3));
      BitReady     = ($urandom_range(0, 9) < 7);
      applyStimulus("rand");
    end

    InValid  = 1'b0;
    BitReady = 1'b1;
    for (int k = 0; k < 12; k++) applyStimulus("final drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
